// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the execute stage and a byte-enabled synchronous-read data memory.
// Misaligned halfword/word accesses are either split into byte accesses or rejected, depending on SPLIT_EN.
module lsu_mem_initiator #(
  parameter int ADDR_W   = 17,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_memop,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [2:0]        mem_memop,
  output logic [ADDR_W-1:0] mem_rdaddr,
  output logic [ADDR_W-1:0] mem_wraddr,
  output logic              mem_wren,
  output logic [31:0]       mem_data,
  input  logic [31:0]       mem_dataout
);

  typedef enum logic [1:0] {IDLE, ACC, CAP, DONE} state_t;

  state_t            state;
  logic              we_q;
  logic              split_q;
  logic [2:0]        memop_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [1:0]        k;
  logic [1:0]        last_k;

  logic [2:0]        size;
  logic [1:0]        size_m1;
  logic [32:0]       end_addr;
  logic              illegal;
  logic              out_of_range;
  logic              misaligned;
  logic              acc_err;
  logic              split_req;
  logic [1:0]        k_inc;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       merged;
  logic [31:0]       final_rdata;

  // Request classification; the 33-bit end address keeps the range test free of wrap-around.
  always_comb begin
    case (req_memop[1:0])
      2'b00:   begin size = 3'd1; size_m1 = 2'd0; end
      2'b01:   begin size = 3'd2; size_m1 = 2'd1; end
      default: begin size = 3'd4; size_m1 = 2'd3; end
    endcase
    illegal      = (req_memop[1:0] == 2'b11) || (req_memop[2] && req_memop[1]) ||
                   (req_we && req_memop[2]);
    end_addr     = {1'b0, req_addr} + {30'd0, size} - 33'd1;
    out_of_range = |end_addr[32:ADDR_W];
    misaligned   = ((req_memop[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_memop[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    acc_err      = illegal || out_of_range || (misaligned && !SPLIT_EN);
    split_req    = misaligned && SPLIT_EN && !acc_err;
  end

  always_comb begin
    k_inc     = k + 2'd1;
    next_addr = addr_q + ADDR_W'(k_inc);
    merged    = asm_q;
    merged[8*k +: 8] = mem_dataout[7:0];
    final_rdata = mem_dataout;
    if (split_q) begin
      if (memop_q[1:0] == 2'b01)
        final_rdata = memop_q[2] ? {16'd0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
      else
        final_rdata = merged;
    end
  end

  // Address/data phases are registered one cycle ahead so the memory sees them during ACC (and CAP for reads).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_memop  <= 3'b010;
      mem_rdaddr <= '0;
      mem_wraddr <= '0;
      mem_wren   <= 1'b0;
      mem_data   <= '0;
      we_q       <= 1'b0;
      split_q    <= 1'b0;
      memop_q    <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      k          <= '0;
      last_k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            memop_q    <= req_memop;
            addr_q     <= req_addr[ADDR_W-1:0];
            wdata_q    <= req_wdata;
            split_q    <= split_req;
            last_k     <= size_m1;
            k          <= 2'd0;
            asm_q      <= '0;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= acc_err;
            if (acc_err) begin
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              state     <= ACC;
              mem_memop <= split_req ? (req_we ? 3'b000 : 3'b100) : req_memop;
              if (req_we) begin
                mem_wraddr <= req_addr[ADDR_W-1:0];
                mem_wren   <= 1'b1;
                mem_data   <= split_req ? {24'd0, req_wdata[7:0]} : req_wdata;
              end else begin
                mem_rdaddr <= req_addr[ADDR_W-1:0];
              end
            end
          end
        end
        ACC: begin
          if (we_q) begin
            if (split_q && (k != last_k)) begin
              k          <= k_inc;
              mem_wraddr <= next_addr;
              mem_data   <= {24'd0, wdata_q[8*k_inc +: 8]};
            end else begin
              mem_wren   <= 1'b0;
              mem_wraddr <= '0;
              mem_data   <= '0;
              mem_memop  <= 3'b010;
              resp_valid <= 1'b1;
              state      <= DONE;
            end
          end else begin
            state <= CAP;
          end
        end
        CAP: begin
          asm_q <= merged;
          if (split_q && (k != last_k)) begin
            k          <= k_inc;
            mem_rdaddr <= next_addr;
            state      <= ACC;
          end else begin
            resp_rdata <= final_rdata;
            mem_rdaddr <= '0;
            mem_memop  <= 3'b010;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: a synchronous-read byte memory plus a byte-array reference model.
// A second instance with SPLIT_EN=0 covers the misaligned-rejection path.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid_s0 = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_memop = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        req_ready, resp_valid, resp_err, mem_wren;
  logic [31:0] resp_rdata, mem_data, mem_dataout;
  logic [2:0]  mem_memop;
  logic [16:0] mem_rdaddr, mem_wraddr;

  logic        req_ready_s0, resp_valid_s0, resp_err_s0, mem_wren_s0;
  logic [31:0] resp_rdata_s0, mem_data_s0;
  logic [31:0] zero_data = '0;
  logic [2:0]  mem_memop_s0;
  logic [16:0] mem_rdaddr_s0, mem_wraddr_s0;

  logic [7:0]  mem [0:131071];
  logic [7:0]  ref_mem [0:131071];

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.ADDR_W(17), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_memop(mem_memop), .mem_rdaddr(mem_rdaddr), .mem_wraddr(mem_wraddr),
    .mem_wren(mem_wren), .mem_data(mem_data), .mem_dataout(mem_dataout)
  );

  lsu_mem_initiator #(.ADDR_W(17), .SPLIT_EN(1'b0)) dut_s0 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid_s0), .req_ready(req_ready_s0),
    .req_we(req_we), .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_s0), .resp_rdata(resp_rdata_s0), .resp_err(resp_err_s0),
    .mem_memop(mem_memop_s0), .mem_rdaddr(mem_rdaddr_s0), .mem_wraddr(mem_wraddr_s0),
    .mem_wren(mem_wren_s0), .mem_data(mem_data_s0), .mem_dataout(zero_data)
  );

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] raw);
    case (op)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b100:  return {24'd0, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b101:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] mem_read(input logic [2:0] op, input logic [16:0] a);
    logic [16:0] a1, a2, a3;
    a1 = a + 17'd1;
    a2 = a + 17'd2;
    a3 = a + 17'd3;
    return extend(op, {mem[a3], mem[a2], mem[a1], mem[a]});
  endfunction

  // Memory block: writes commit and the read address is sampled on the same edge.
  always @(posedge clk) begin
    if (mem_wren) begin
      mem[mem_wraddr] <= mem_data[7:0];
      if (mem_memop[1:0] != 2'b00) mem[mem_wraddr + 17'd1] <= mem_data[15:8];
      if (mem_memop[1:0] == 2'b10) begin
        mem[mem_wraddr + 17'd2] <= mem_data[23:16];
        mem[mem_wraddr + 17'd3] <= mem_data[31:24];
      end
    end
    mem_dataout <= mem_read(mem_memop, mem_rdaddr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction: the expected outcome is derived from the access rules and ref_mem, then compared.
  task automatic applyStimulus(input string name, input bit use_s0, input bit we,
                               input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    int n, exp_lat, exp_nw, got_lat;
    bit illegal, out_range, mis, exp_err, split;
    logic [31:0] exp_rdata, got_rdata, raw;
    logic [16:0] wa_q[$];
    logic [2:0]  wop_q[$];
    logic [31:0] wd_q[$];
    logic        got_err;
    logic [16:0] ea;
    n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    illegal   = (op == 3'b011) || (op == 3'b110) || (op == 3'b111) || (we && op[2]);
    out_range = (longint'(addr) + longint'(n) - 1) >= 64'd131072;
    mis       = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    exp_err   = illegal || out_range || (mis && use_s0);
    split     = mis && !use_s0 && !exp_err;
    exp_rdata = '0;
    exp_nw    = 0;
    if (exp_err) exp_lat = 1;
    else if (we) begin
      exp_lat = split ? n + 1 : 2;
      exp_nw  = split ? n : 1;
      for (int i = 0; i < n; i++) begin
        ea = addr[16:0] + 17'(i);
        ref_mem[ea] = wdata[8*i +: 8];
      end
    end else begin
      exp_lat = split ? 2 * n + 1 : 3;
      raw = '0;
      for (int i = 0; i < n; i++) begin
        ea = addr[16:0] + 17'(i);
        raw[8*i +: 8] = ref_mem[ea];
      end
      exp_rdata = extend(op, raw);
    end

    @(negedge clk);
    checkOutput({name, " ready"}, 32'(use_s0 ? req_ready_s0 : req_ready), 32'd1);
    req_we = we; req_memop = op; req_addr = addr; req_wdata = wdata;
    if (use_s0) req_valid_s0 = 1'b1; else req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; req_valid_s0 = 1'b0;
    got_lat = 0; got_rdata = 'x; got_err = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (use_s0 ? mem_wren_s0 : mem_wren) begin
        wa_q.push_back(use_s0 ? mem_wraddr_s0 : mem_wraddr);
        wop_q.push_back(use_s0 ? mem_memop_s0 : mem_memop);
        wd_q.push_back(use_s0 ? mem_data_s0 : mem_data);
      end
      if (use_s0 ? resp_valid_s0 : resp_valid) begin
        got_lat   = c;
        got_rdata = use_s0 ? resp_rdata_s0 : resp_rdata;
        got_err   = use_s0 ? resp_err_s0 : resp_err;
        break;
      end
    end
    checkOutput({name, " latency"}, 32'(got_lat), 32'(exp_lat));
    checkOutput({name, " err"}, 32'(got_err), 32'(exp_err));
    checkOutput({name, " rdata"}, got_rdata, exp_rdata);
    checkOutput({name, " writes"}, 32'(wa_q.size()), 32'(exp_nw));
    for (int i = 0; i < wa_q.size() && i < exp_nw; i++) begin
      checkOutput($sformatf("%s wraddr%0d", name, i), 32'(wa_q[i]), 32'(addr[16:0] + 17'(split ? i : 0)));
      checkOutput($sformatf("%s wmemop%0d", name, i), 32'(wop_q[i]), 32'(split ? 3'b000 : op));
      checkOutput($sformatf("%s wdata%0d", name, i), wd_q[i], split ? {24'd0, wdata[8*i +: 8]} : wdata);
    end
    if (got_lat != 0) begin
      @(negedge clk);
      checkOutput({name, " pulse"}, 32'(use_s0 ? resp_valid_s0 : resp_valid), 32'd0);
    end
    last_rdata = got_rdata;
  endtask

  task automatic check_reset_outputs(input string name);
    checkOutput({name, " ready"}, 32'(req_ready), 32'd1);
    checkOutput({name, " valid"}, 32'(resp_valid), 32'd0);
    checkOutput({name, " rdata"}, resp_rdata, 32'd0);
    checkOutput({name, " err"}, 32'(resp_err), 32'd0);
    checkOutput({name, " memop"}, 32'(mem_memop), 32'h2);
    checkOutput({name, " addrs"}, 32'(mem_rdaddr) | 32'(mem_wraddr), 32'd0);
    checkOutput({name, " wren"}, 32'(mem_wren), 32'd0);
    checkOutput({name, " data"}, mem_data, 32'd0);
  endtask

  initial begin
    logic [2:0]  ops [8];
    logic [31:0] ra;
    int          r, seen_valid;
    ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    for (int a = 32'hF0; a < 32'h138; a += 4) applyStimulus("clear", 1'b0, 1'b1, 3'b010, 32'(a), 32'd0);
    for (int a = 32'h1FFF0; a < 32'h20000; a += 4) applyStimulus("clear_top", 1'b0, 1'b1, 3'b010, 32'(a), 32'd0);
    applyStimulus("pre0", 1'b0, 1'b1, 3'b010, 32'h100, 32'h44332211);
    applyStimulus("pre1", 1'b0, 1'b1, 3'b010, 32'h104, 32'h88776655);

    applyStimulus("lw100", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("lw100 const", last_rdata, 32'h44332211);
    applyStimulus("lw103", 1'b0, 1'b0, 3'b010, 32'h103, 32'h0);
    checkOutput("lw103 const", last_rdata, 32'h77665544);
    applyStimulus("lh105", 1'b0, 1'b0, 3'b001, 32'h105, 32'h0);
    checkOutput("lh105 const", last_rdata, 32'h00007766);
    applyStimulus("lh106", 1'b0, 1'b0, 3'b001, 32'h106, 32'h0);
    checkOutput("lh106 const", last_rdata, 32'hFFFF8877);
    applyStimulus("lhu106", 1'b0, 1'b0, 3'b101, 32'h106, 32'h0);
    checkOutput("lhu106 const", last_rdata, 32'h00008877);

    applyStimulus("sw101", 1'b0, 1'b1, 3'b010, 32'h101, 32'hAABBCCDD);
    applyStimulus("rb100", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("rb100 const", last_rdata, 32'hBBCCDD11);
    applyStimulus("rb104", 1'b0, 1'b0, 3'b010, 32'h104, 32'h0);
    checkOutput("rb104 const", last_rdata, 32'h887766AA);

    applyStimulus("err_range", 1'b0, 1'b0, 3'b010, 32'h20000, 32'h0);
    applyStimulus("err_end", 1'b0, 1'b0, 3'b010, 32'h1FFFE, 32'h0);
    applyStimulus("err_op3", 1'b0, 1'b0, 3'b011, 32'h100, 32'h0);
    applyStimulus("err_sbu", 1'b0, 1'b1, 3'b100, 32'h100, 32'h12345678);
    applyStimulus("err_nosplit", 1'b1, 1'b0, 3'b001, 32'h101, 32'h0);

    applyStimulus("pre0b", 1'b0, 1'b1, 3'b010, 32'h100, 32'h44332211);
    applyStimulus("pre1b", 1'b0, 1'b1, 3'b010, 32'h104, 32'h88776655);
    @(negedge clk);
    req_we = 1'b1; req_memop = 3'b010; req_addr = 32'h101; req_wdata = 32'hAABBCCDD;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    #2;
    check_reset_outputs("midrst");
    seen_valid = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen_valid++;
    end
    checkOutput("midrst no_resp", 32'(seen_valid), 32'd0);
    rstn = 1'b1;
    ref_mem[17'h101] = 8'hDD;
    ref_mem[17'h102] = 8'hCC;
    applyStimulus("rst_rb0", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("rst_rb0 const", last_rdata, 32'h44CCDD11);
    applyStimulus("rst_rb1", 1'b0, 1'b0, 3'b010, 32'h104, 32'h0);
    checkOutput("rst_rb1 const", last_rdata, 32'h88776655);

    for (int t = 0; t < 80; t++) begin
      r  = int'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? 32'h1FFF0 + $urandom_range(0, 23) : 32'hF0 + $urandom_range(0, 63);
      applyStimulus($sformatf("rnd%0d", t), 1'b0, 1'($urandom_range(0, 1)),
                    ops[r < 13 ? r % 5 : 5 + r % 3], ra, $urandom);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator between the CPU execute stage and the byte-enabled data memory block.
- Accepts one request at a time over a valid/ready handshake.
- Drives the memory's memop/rdaddr/wraddr/wren/data interface and accounts for the memory's one-cycle synchronous read.
- Splits misaligned halfword/word accesses into sequential byte accesses, then returns assembled, sign- or zero-extended load data with an error flag.

Parameters:
ADDR_W, 17, memory byte-address width; addresses at or above 2^ADDR_W are out of range.
SPLIT_EN, 1, 1 = split misaligned accesses into byte accesses; 0 = flag them as errors.

Ports:
clk  input  1  single clock; also drives the memory rdclk/wrclk.
rstn  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE.
req_we  input  1  1 = store, 0 = load.
req_memop  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
req_addr  input  32  byte address.
req_wdata  input  32  store data, low bytes used for b/h.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  load result; 0 for stores and errors.
resp_err  output  1  illegal memop, out-of-range address, or misaligned access with SPLIT_EN=0.
mem_memop  output  3  memop to memory.
mem_rdaddr  output  ADDR_W  read byte address.
mem_wraddr  output  ADDR_W  write byte address.
mem_wren  output  1  write enable.
mem_data  output  32  write data.
mem_dataout  input  32  memory read data, valid the cycle after the address is sampled.

Behaviour:
- Reset (asynchronous, rstn=0): state IDLE; all outputs 0 except req_ready=1; mem_memop=010.
- Idle drive values: mem_wren=0, addresses 0, mem_data 0, mem_memop 010.
- Accept: on a clock edge with req_valid && req_ready, register all request fields.
- Error detection at accept:
  - memop 011/110/111 is an error.
  - A store with memop[2]=1 is an error.
  - Size n = 1/2/4. The range test is end address = addr+n-1 ≥ 2^ADDR_W.
  - Misalignment: h with addr[0]=1; w with addr[1:0]≠0.
- Error path: ACC skipped, DONE next with resp_err=1. No memory access; mem_wren never asserted.
- States and cycle timing:
  - IDLE → ACC → (load) CAP → DONE → IDLE.
  - ACC: drive the address.
    - Store: mem_wren=1; the write commits at the end of ACC.
    - Load: the memory samples the address at the end of ACC.
  - CAP: mem_dataout is valid and is registered into the assembly register at the end of CAP.
  - DONE: resp_valid=1 for exactly one cycle.
- Latency from the accept edge to the resp_valid cycle:
  - Aligned load: 3rd cycle.
  - Aligned store: 2nd cycle.
  - Error: 1st cycle.
- Misaligned split (SPLIT_EN=1):
  - Byte counter k = 0..n-1.
  - Load: n (ACC, CAP) pairs with memop 100 at addr+k; mem_dataout[7:0] goes to assembly bits [8k+7:8k]. The final value is sign-extended (h, w unchanged) or zero-extended (hu) per the original memop. Latency is 2n+1.
  - Store: n ACC cycles with memop 000, wraddr=addr+k, mem_data byte = req_wdata[8k+7:8k]. Latency is n+1.
- Aligned access: a single access with the original memop, mem_data=req_wdata, and mem_dataout taken as returned.
- resp_rdata is held until the next accept; it is 0 for stores and errors.
- No response backpressure.
- Reset mid-operation: aborts immediately. Bytes already written remain in memory (no rollback); unwritten bytes are untouched. No resp_valid.
- Address arithmetic is modulo 2^ADDR_W internally; the end-address range check prevents wrap.

Test Plan:
- Preload: word 0x100=0x44332211, word 0x104=0x88776655.
- lw 0x100 → resp_rdata=0x44332211, resp_err=0, resp_valid in the 3rd cycle after accept.
- lw 0x103 → four memop 100 reads at 0x103..0x106 → 0x77665544, resp_valid in the 9th cycle after accept.
- lh 0x105 (split) → 0x00007766; lh 0x106 (aligned, memop 001) → 0xFFFF8877; lhu 0x106 → 0x00008877.
- sw 0x101 data 0xAABBCCDD → 4 sb cycles with wraddr 0x101..0x104.
  - Readback: lw 0x100=0xBBCCDD11, lw 0x104=0x887766AA.
- Errors: lw 0x20000, lw 0x1FFFE (end address 0x20001), memop 011, sb with memop 100, and (SPLIT_EN=0) lh 0x101.
  - Each gives resp_err=1, rdata=0, mem_wren never high, resp_valid in the 1st cycle after accept.
- Reset mid-operation: rstn low after the 2nd sb of sw 0x101.
  - All outputs 0 and req_ready=1 while reset is asserted; no resp_valid.
  - After release, bytes 0x101–0x102 are updated and 0x103–0x104 keep their original values.
